// File: rtl/core_sequencer_if.sv
// core_sequencer_if
//   Instruction- and data-memory handshake bundle for the core sequencer.
//   master : sequencer side (drives requests, addresses, store data)
//   slave  : memory side    (drives acks and read data)
//   imem_*  : instruction fetch, imem_rdata valid in the imem_ack cycle
//   dmem_*  : data access, dmem_we selects write, dmem_rdata valid with dmem_ack
interface core_sequencer_if #(
   parameter int PC_W = 16
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic [15:0]     dmem_addr;
   logic [15:0]     dmem_wdata;
   logic [15:0]     dmem_rdata;
   logic            dmem_ack;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer
//   Multi-cycle fetch/execute controller for the nandgameplus core.
//   Fetches an instruction, optionally loads mem[A], lets the ALU compute,
//   optionally stores the result to mem[A], then writes back and advances pc.
// Ports
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_run           : level, 1 = keep executing, 0 = stop after current instr
//   m_bus           : imem/dmem handshakes (master side)
//   o_instr         : current instruction to register file / ALU
//   i_a_val         : A register value
//   i_alu_result    : ALU result for o_instr
//   o_mem_operand   : latched mem[A] for load-type compute instructions
//   o_wb_sel        : 0 = ALU result, 1 = immediate
//   o_reg_write     : register-file write enable (one-cycle pulse in WB)
//   o_pc            : program counter
//   o_retired       : one-cycle pulse per completed instruction
//   o_busy          : 1 outside IDLE/FAULT
//   o_fault         : sticky ack-timeout flag
module core_sequencer #(
   parameter int PC_W    = 16,
   parameter int TIMEOUT = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_run,
   core_sequencer_if.master m_bus,
   output logic [15:0]      o_instr,
   input  logic [15:0]      i_a_val,
   input  logic [15:0]      i_alu_result,
   output logic [15:0]      o_mem_operand,
   output logic             o_wb_sel,
   output logic             o_reg_write,
   output logic [PC_W-1:0]  o_pc,
   output logic             o_retired,
   output logic             o_busy,
   output logic             o_fault
);

   // Counter only needs to reach TIMEOUT-1: the cycle that would make it
   // TIMEOUT is the one that moves to FAULT.
   localparam int                CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  TO_LIM = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DMEM_RD, S_EXEC, S_DMEM_WR, S_WB, S_FAULT
   } state_t;

   state_t           r_state;
   logic [PC_W-1:0]  r_pc;
   logic [15:0]      r_instr;
   logic [15:0]      r_mem_op;
   logic [15:0]      r_res;
   logic [15:0]      r_tgt;
   logic             r_taken;
   logic [CNT_W-1:0] r_cnt;
   logic             r_imem_req;
   logic             r_dmem_req;
   logic             r_dmem_we;
   logic [15:0]      r_dmem_addr;
   logic             r_reg_write;
   logic             r_retired;
   logic             r_busy;
   logic             r_fault;

   state_t      w_nxt;
   logic        w_imem_ack;
   logic        w_dmem_ack;
   logic        w_to;
   logic [15:0] w_res;
   logic        w_taken;
   logic        w_wr_tgt;

   // Acks are only meaningful while the matching request is up.
   assign w_imem_ack = m_bus.imem_ack & r_imem_req;
   assign w_dmem_ack = m_bus.dmem_ack & r_dmem_req;
   assign w_to       = (TIMEOUT > 0) && (r_cnt == TO_LIM);

   assign w_res   = r_instr[15] ? i_alu_result : {1'b0, r_instr[14:0]};
   // Signed compare on the captured result; immediates never jump.
   assign w_taken = r_instr[15] &
                    ((r_instr[5] &  w_res[15]) |
                     (r_instr[4] & (w_res == 16'h0000)) |
                     (r_instr[3] & ~w_res[15] & (w_res != 16'h0000)));
   // Targets 000/001/010 write D/A/SP; 011 and 1xx write nothing.
   assign w_wr_tgt = ~r_instr[15] | (r_instr[2:0] <= 3'd2);

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:    if (i_run) w_nxt = S_FETCH;
         S_FETCH: begin
            if (w_imem_ack)
               w_nxt = (m_bus.imem_rdata[15] & m_bus.imem_rdata[14]) ? S_DMEM_RD : S_EXEC;
            else if (w_to)
               w_nxt = S_FAULT;
         end
         S_DMEM_RD: begin
            if (w_dmem_ack)  w_nxt = S_EXEC;
            else if (w_to)   w_nxt = S_FAULT;
         end
         S_EXEC:    w_nxt = (r_instr[15] & r_instr[9]) ? S_DMEM_WR : S_WB;
         S_DMEM_WR: begin
            if (w_dmem_ack)  w_nxt = S_WB;
            else if (w_to)   w_nxt = S_FAULT;
         end
         S_WB:      w_nxt = i_run ? S_FETCH : S_IDLE;
         S_FAULT:   w_nxt = S_FAULT;
         default:   w_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one is valid for
   // exactly the cycles spent in the state that owns it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_instr     <= '0;
         r_mem_op    <= '0;
         r_res       <= '0;
         r_tgt       <= '0;
         r_taken     <= 1'b0;
         r_cnt       <= '0;
         r_imem_req  <= 1'b0;
         r_dmem_req  <= 1'b0;
         r_dmem_we   <= 1'b0;
         r_dmem_addr <= '0;
         r_reg_write <= 1'b0;
         r_retired   <= 1'b0;
         r_busy      <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         // An ack always changes state, so "same state with a req up" is
         // exactly a wait cycle.
         r_cnt       <= ((w_nxt == r_state) && (r_imem_req || r_dmem_req)) ?
                        r_cnt + 1'b1 : '0;
         r_imem_req  <= (w_nxt == S_FETCH);
         r_dmem_req  <= (w_nxt == S_DMEM_RD) || (w_nxt == S_DMEM_WR);
         r_dmem_we   <= (w_nxt == S_DMEM_WR);
         r_reg_write <= (w_nxt == S_WB) && w_wr_tgt;
         r_retired   <= (w_nxt == S_WB);
         r_busy      <= (w_nxt != S_IDLE) && (w_nxt != S_FAULT);
         r_fault     <= (w_nxt == S_FAULT);

         if (r_state == S_FETCH && w_imem_ack)
            r_instr <= m_bus.imem_rdata;
         // Address is captured on entry so it holds steady through waits.
         if (r_state == S_FETCH && w_nxt == S_DMEM_RD)
            r_dmem_addr <= i_a_val;
         if (r_state == S_DMEM_RD && w_dmem_ack)
            r_mem_op <= m_bus.dmem_rdata;
         if (r_state == S_EXEC) begin
            r_res   <= w_res;
            r_tgt   <= i_a_val;
            r_taken <= w_taken;
            if (w_nxt == S_DMEM_WR)
               r_dmem_addr <= i_a_val;
         end
         if (r_state == S_WB)
            r_pc <= r_taken ? PC_W'(r_tgt) : r_pc + 1'b1;
      end
   end

   assign m_bus.imem_req   = r_imem_req;
   assign m_bus.imem_addr  = r_pc;
   assign m_bus.dmem_req   = r_dmem_req;
   assign m_bus.dmem_we    = r_dmem_we;
   assign m_bus.dmem_addr  = r_dmem_addr;
   assign m_bus.dmem_wdata = r_res;

   assign o_instr       = r_instr;
   assign o_mem_operand = r_mem_op;
   assign o_wb_sel      = ~r_instr[15];
   assign o_reg_write   = r_reg_write;
   assign o_pc          = r_pc;
   assign o_retired     = r_retired;
   assign o_busy        = r_busy;
   assign o_fault       = r_fault;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [15:0] instr, a_val, alu_result, mem_operand;
   logic        wb_sel, reg_write, retired, busy, fault;
   logic [15:0] pc;

   int n_cmp = 0;
   int n_err = 0;

   // memory models
   logic [15:0] prog [0:1023];
   int          im_lat, dm_lat, icnt, dcnt;
   logic        im_en;
   logic [15:0] dm_rdata;
   logic [15:0] wr_addr, wr_data;

   core_sequencer_if #(.PC_W(16)) bus();

   core_sequencer #(.PC_W(16), .TIMEOUT(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_run        (run),
      .m_bus        (bus),
      .o_instr      (instr),
      .i_a_val      (a_val),
      .i_alu_result (alu_result),
      .o_mem_operand(mem_operand),
      .o_wb_sel     (wb_sel),
      .o_reg_write  (reg_write),
      .o_pc         (pc),
      .o_retired    (retired),
      .o_busy       (busy),
      .o_fault      (fault)
   );

   always #5 clk = ~clk;

   // ack after a programmable number of wait cycles
   assign bus.imem_ack   = bus.imem_req && im_en && (icnt == im_lat);
   assign bus.imem_rdata = prog[bus.imem_addr[9:0]];
   assign bus.dmem_ack   = bus.dmem_req && (dcnt == dm_lat);
   assign bus.dmem_rdata = dm_rdata;

   always_ff @(posedge clk) begin
      icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
      dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
      if (bus.dmem_req && bus.dmem_we && bus.dmem_ack) begin
         wr_addr <= bus.dmem_addr;
         wr_data <= bus.dmem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ticks until a retired pulse is seen; -1 if it never comes
   task automatic wait_ret(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!retired && n < 20);
      if (!retired) n = -1;
   endtask

   int n, k;

   initial begin
      for (int i = 0; i < 1024; i++) prog[i] = 16'h0000;
      prog[16'h000] = 16'h0005;  // immediate
      prog[16'h001] = 16'h8010;  // compute, jump eq, -> D
      prog[16'h040] = 16'h8010;
      prog[16'h041] = 16'hC007;  // load mem[A], no target
      prog[16'h042] = 16'h8203;  // store, no target
      prog[16'h043] = 16'hC208;  // load+store, jump gt, -> D
      prog[16'h100] = 16'h8020;  // jump lt, -> D
      prog[16'h200] = 16'h0007;  // immediate
      prog[16'h201] = 16'h8200;  // store, -> D
      im_lat = 0; dm_lat = 0; im_en = 1'b1; icnt = 0; dcnt = 0;
      dm_rdata = 16'h0000; wr_addr = 16'h0; wr_data = 16'h0;
      rst_n = 1'b0; run = 1'b0; a_val = 16'h0040; alu_result = 16'h0000;
      tick(); tick();
      chk("rst_pc", pc, 16'h0);
      chk("rst_instr", instr, 16'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_ireq", bus.imem_req, 1'b0);
      chk("rst_rw", reg_write, 1'b0);

      // immediate, zero-wait
      rst_n = 1'b1; run = 1'b1;
      tick();
      chk("imm_ireq_c1", bus.imem_req, 1'b1);
      chk("imm_iaddr", bus.imem_addr, 16'h0);
      tick();
      chk("imm_instr", instr, 16'h0005);
      tick();
      chk("imm_ret_c3", retired, 1'b1);
      chk("imm_rw_c3", reg_write, 1'b1);
      chk("imm_wbsel", wb_sel, 1'b1);
      tick();
      chk("imm_pc", pc, 16'h1);
      chk("imm_ireq_c4", bus.imem_req, 1'b1);
      chk("imm_ret_off", retired, 1'b0);

      // jump eq taken
      wait_ret(n);
      chk("jeq_lat", n, 2);
      chk("jeq_rw", reg_write, 1'b1);
      chk("jeq_wbsel", wb_sel, 1'b0);
      tick();
      chk("jeq_pc", pc, 16'h0040);

      // jump eq not taken
      alu_result = 16'h0001;
      wait_ret(n);
      chk("jne_lat", n, 2);
      tick();
      chk("jne_pc", pc, 16'h0041);

      // load with 2 wait cycles
      a_val = 16'h0010; dm_lat = 2; dm_rdata = 16'hBEEF;
      tick();
      chk("ld_req", bus.dmem_req, 1'b1);
      chk("ld_we", bus.dmem_we, 1'b0);
      chk("ld_addr", bus.dmem_addr, 16'h0010);
      wait_ret(n);
      chk("ld_lat", n, 4);
      chk("ld_memop", mem_operand, 16'hBEEF);
      chk("ld_rw", reg_write, 1'b0);
      tick();
      chk("ld_pc", pc, 16'h0042);

      // store, no register target
      alu_result = 16'h1234; a_val = 16'h0020; dm_lat = 0;
      tick();
      tick();
      chk("st_req", bus.dmem_req, 1'b1);
      chk("st_we", bus.dmem_we, 1'b1);
      chk("st_addr", bus.dmem_addr, 16'h0020);
      chk("st_wdata", bus.dmem_wdata, 16'h1234);
      tick();
      chk("st_ret", retired, 1'b1);
      chk("st_rw", reg_write, 1'b0);
      chk("st_mem_addr", wr_addr, 16'h0020);
      chk("st_mem_data", wr_data, 16'h1234);
      tick();
      chk("st_pc", pc, 16'h0043);

      // load + store, jump gt on 7FFF
      alu_result = 16'h7FFF; a_val = 16'h0100; dm_rdata = 16'h5555;
      wait_ret(n);
      chk("ldst_lat", n, 4);
      chk("ldst_rw", reg_write, 1'b1);
      tick();
      chk("jgt_pc", pc, 16'h0100);

      // jump lt on 8000 (negative)
      alu_result = 16'h8000; a_val = 16'h0200;
      wait_ret(n);
      chk("jlt_lat", n, 2);
      tick();
      chk("jlt_pc", pc, 16'h0200);

      // run drops during EXEC
      tick();
      run = 1'b0;
      tick();
      chk("stop_ret", retired, 1'b1);
      chk("stop_rw", reg_write, 1'b1);
      tick();
      chk("stop_busy", busy, 1'b0);
      chk("stop_ireq", bus.imem_req, 1'b0);
      chk("stop_pc", pc, 16'h0201);
      tick();
      chk("idle_ireq", bus.imem_req, 1'b0);

      // reset while a store is waiting
      run = 1'b1; dm_lat = 10; a_val = 16'h0030; alu_result = 16'h4321;
      tick(); tick(); tick();
      chk("wr_req", bus.dmem_req, 1'b1);
      chk("wr_we", bus.dmem_we, 1'b1);
      tick();
      chk("wr_addr_hold", bus.dmem_addr, 16'h0030);
      rst_n = 1'b0; run = 1'b0;
      tick();
      chk("abort_dreq", bus.dmem_req, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_pc", pc, 16'h0);
      chk("abort_instr", instr, 16'h0);
      chk("abort_memop", mem_operand, 16'h0);
      chk("abort_ret", retired, 1'b0);
      rst_n = 1'b1;

      // ack on the last allowed wait cycle wins over the watchdog
      im_lat = 3; dm_lat = 0; run = 1'b1;
      tick();
      wait_ret(n);
      chk("edge_lat", n, 5);
      chk("edge_fault", fault, 1'b0);
      run = 1'b0;
      tick();

      // imem never acks -> FAULT
      im_en = 1'b0; run = 1'b1;
      tick();
      k = 0;
      while (bus.imem_req && k < 20) begin
         k++;
         tick();
      end
      chk("to_wait", k, 4);
      chk("to_fault", fault, 1'b1);
      chk("to_busy", busy, 1'b0);
      tick(); tick(); tick();
      chk("to_ireq", bus.imem_req, 1'b0);
      chk("to_sticky", fault, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("to_rst_fault", fault, 1'b0);
      chk("to_rst_pc", pc, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
